// File: rtl/l2_cache_fill_engine.sv
// l2_cache_fill_engine
//
// Services L2 misses after they leave the L2 pipeline. Each miss is queued as
// {line address, duplicate flag}. For a non-duplicate head entry the engine
// issues one line read to system memory. It then assembles the returned
// 32-bit beats into a full line and re-injects the request into the L2
// pipeline as a fill. A duplicate head entry is re-injected straight away,
// with no data, so that the pipeline rereads the line from the cache. Fills
// leave strictly in enqueue order. Only the head entry is ever serviced, so
// at most one memory read is outstanding.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   enqueue_valid/addr    miss request from the L2 miss path
//   enqueue_duplicate     a miss for this line is already pending (no read)
//   queue_almost_full     occupancy >= QUEUE_SIZE - ALMOST_FULL_MARGIN
//   mem_read_valid/ready  line read request handshake to system memory
//   mem_read_addr         line address being read
//   mem_data_valid/data   returned data beats, first beat = most significant word
//   fill_valid/ready      fill handshake towards the L2 arbiter
//   fill_addr/data        line address and assembled line (zero for duplicates)
//   fill_is_duplicate     fill carries no data
module l2_cache_fill_engine #(
  parameter int QUEUE_SIZE         = 16,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int BEATS              = 16,
  parameter int LINE_INDEX_WIDTH   = 26
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enqueue_valid,
  input  logic [LINE_INDEX_WIDTH-1:0] enqueue_addr,
  input  logic                        enqueue_duplicate,
  output logic                        queue_almost_full,
  output logic                        mem_read_valid,
  input  logic                        mem_read_ready,
  output logic [LINE_INDEX_WIDTH-1:0] mem_read_addr,
  input  logic                        mem_data_valid,
  input  logic [31:0]                 mem_data,
  output logic                        fill_valid,
  input  logic                        fill_ready,
  output logic [LINE_INDEX_WIDTH-1:0] fill_addr,
  output logic [BEATS*32-1:0]         fill_data,
  output logic                        fill_is_duplicate
);

  localparam int LINE_BITS = BEATS * 32;
  localparam int PTR_W     = $clog2(QUEUE_SIZE);
  localparam int BEAT_W    = $clog2(BEATS);

  localparam logic [PTR_W:0]    FULL_LEVEL = (PTR_W + 1)'(QUEUE_SIZE);
  localparam logic [PTR_W:0]    AF_LEVEL   = (PTR_W + 1)'(QUEUE_SIZE - ALMOST_FULL_MARGIN);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FILL} state_t;

  state_t state, next_state;

  logic [LINE_INDEX_WIDTH-1:0] addr_mem [QUEUE_SIZE];
  logic                        dup_mem  [QUEUE_SIZE];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [PTR_W:0]              count;
  logic [BEAT_W-1:0]           beat_count;
  logic [LINE_BITS-1:0]        line_buf;

  logic                        push, pop;
  logic [LINE_INDEX_WIDTH-1:0] head_addr;
  logic                        head_dup;

  // A push into a full queue is dropped, leaving the state untouched.
  // Popping is tied to the fill handshake, which can only happen in FILL,
  // and the queue is never empty in that state.
  assign push      = enqueue_valid && (count != FULL_LEVEL);
  assign pop       = (state == FILL) && fill_ready;
  assign head_addr = addr_mem[rd_ptr];
  assign head_dup  = dup_mem[rd_ptr];

  // The threshold is taken from the registered count only, so an enqueue
  // shows up in the cycle after the edge that captured it.
  assign queue_almost_full = (count >= AF_LEVEL);

  // The storage needs no reset, because entries are only read below the
  // count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= enqueue_addr;
      dup_mem[wr_ptr]  <= enqueue_duplicate;
    end
  end

  // The pointers wrap naturally because QUEUE_SIZE is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (count != '0) next_state = head_dup ? FILL : ADDR;
      ADDR: if (mem_read_ready) next_state = DATA;
      DATA: if (mem_data_valid && beat_count == LAST_BEAT) next_state = FILL;
      FILL: if (fill_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Beat 0 lands in the most significant word of the line. The counter
  // holds at the last beat because the engine leaves DATA on that beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count <= '0;
      line_buf   <= '0;
    end else if (state == ADDR && mem_read_ready) begin
      beat_count <= '0;
    end else if (state == DATA && mem_data_valid) begin
      line_buf[LINE_BITS - 32 * (int'(beat_count) + 1) +: 32] <= mem_data;
      if (beat_count != LAST_BEAT) beat_count <= beat_count + 1'b1;
    end
  end

  // Outputs are gated by state, so they read as zero everywhere else,
  // including straight after reset.
  always_comb begin
    mem_read_valid    = 1'b0;
    mem_read_addr     = '0;
    fill_valid        = 1'b0;
    fill_addr         = '0;
    fill_data         = '0;
    fill_is_duplicate = 1'b0;
    case (state)
      ADDR: begin
        mem_read_valid = 1'b1;
        mem_read_addr  = head_addr;
      end
      FILL: begin
        fill_valid        = 1'b1;
        fill_addr         = head_addr;
        fill_is_duplicate = head_dup;
        fill_data         = head_dup ? '0 : line_buf;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // Upstream must honour queue_almost_full, so a push into a full queue is
  // a protocol error.
  push_while_full: assert property (@(posedge clk) disable iff (reset)
    !(enqueue_valid && count == FULL_LEVEL))
    else $error("enqueue dropped: pending-request queue is full");

  // Beats outside DATA are dropped. This is expected after a reset that
  // abandons a read, so it is reported as a warning only.
  stray_beat: assert property (@(posedge clk) disable iff (reset)
    mem_data_valid |-> state == DATA)
    else $warning("memory data beat outside DATA ignored");
`endif

endmodule

// File: tb/tb_l2_cache_fill_engine.sv
// tb_l2_cache_fill_engine
//
// Drives l2_cache_fill_engine with directed scenarios followed by randomized
// rounds. The reference model is a queue of outstanding {addr, duplicate}
// requests plus a queue of expected lines, built from the beats that the bench
// itself sends. A negedge monitor checks every fill handshake against the
// head of the model. It also checks that valid outputs hold stable under
// backpressure, and that queue_almost_full follows the model occupancy.
module tb_l2_cache_fill_engine;

  localparam int AW    = 26;
  localparam int BEATS = 16;
  localparam int LB    = BEATS * 32;
  localparam int AF    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          enqueue_valid;
  logic [AW-1:0] enqueue_addr;
  logic          enqueue_duplicate;
  logic          queue_almost_full;
  logic          mem_read_valid;
  logic          mem_read_ready;
  logic [AW-1:0] mem_read_addr;
  logic          mem_data_valid;
  logic [31:0]   mem_data;
  logic          fill_valid;
  logic          fill_ready;
  logic [AW-1:0] fill_addr;
  logic [LB-1:0] fill_data;
  logic          fill_is_duplicate;

  l2_cache_fill_engine #(
    .QUEUE_SIZE(16), .ALMOST_FULL_MARGIN(4), .BEATS(BEATS), .LINE_INDEX_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .enqueue_valid(enqueue_valid), .enqueue_addr(enqueue_addr),
    .enqueue_duplicate(enqueue_duplicate), .queue_almost_full(queue_almost_full),
    .mem_read_valid(mem_read_valid), .mem_read_ready(mem_read_ready),
    .mem_read_addr(mem_read_addr), .mem_data_valid(mem_data_valid),
    .mem_data(mem_data), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_is_duplicate(fill_is_duplicate)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] q_addr [$];
  bit            q_dup [$];
  logic [LB-1:0] exp_lines [$];

  int compared = 0;
  int mismatched = 0;
  int rd_handshakes = 0;
  int fills_done = 0;

  task automatic checkOutput(input string tag, input logic [LB-1:0] actual,
                             input logic [LB-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enqueue one request. The model sees it after the capturing edge.
  task automatic applyStimulus(input logic [AW-1:0] a, input bit d);
    enqueue_valid     = 1'b1;
    enqueue_addr      = a;
    enqueue_duplicate = d;
    step();
    enqueue_valid     = 1'b0;
    enqueue_duplicate = 1'b0;
    q_addr.push_back(a);
    q_dup.push_back(d);
  endtask

  task automatic do_read(input int rd_delay);
    int n = 0;
    while (!mem_read_valid && n < 50) begin step(); n++; end
    if (!mem_read_valid) begin
      checkOutput("rd_timeout", 0, 1);
      return;
    end
    checkOutput("rd_addr", mem_read_addr, q_addr.size() > 0 ? q_addr[0] : '1);
    repeat (rd_delay) step();
    mem_read_ready = 1'b1;
    step();
    mem_read_ready = 1'b0;
  endtask

  task automatic send_beats(input int first, input int last, input int max_gap,
                            input bit use_index, inout logic [LB-1:0] line);
    for (int b = first; b <= last; b++) begin
      repeat ($urandom_range(0, max_gap)) step();
      mem_data       = use_index ? 32'(b) : $urandom;
      mem_data_valid = 1'b1;
      line[LB - 32 * (b + 1) +: 32] = mem_data;
      step();
      mem_data_valid = 1'b0;
    end
  endtask

  task automatic wait_fill(output bit ok);
    int n = 0;
    while (!fill_valid && n < 50) begin step(); n++; end
    ok = fill_valid;
    if (!ok) checkOutput("fill_timeout", 0, 1);
  endtask

  task automatic do_fill(input int fill_delay);
    bit ok;
    wait_fill(ok);
    if (!ok) return;
    repeat (fill_delay) step();
    fill_ready = 1'b1;
    step();
    fill_ready = 1'b0;
  endtask

  task automatic service(input int rd_delay, input int fill_delay, input int max_gap);
    logic [LB-1:0] line = '0;
    if (q_addr.size() == 0) return;
    if (!q_dup[0]) begin
      do_read(rd_delay);
      send_beats(0, BEATS - 1, max_gap, 1'b0, line);
      exp_lines.push_back(line);
    end
    do_fill(fill_delay);
  endtask

  // Monitor: stability under backpressure, occupancy flag, fill scoreboard.
  bit            rd_hold, fill_hold;
  logic [AW-1:0] rd_hold_addr, fill_hold_addr;
  logic [LB-1:0] fill_hold_data;
  logic          fill_hold_dup;

  always @(negedge clk) begin
    logic [AW-1:0] ea;
    bit            ed;
    logic [LB-1:0] el;
    if (reset) begin
      rd_hold   = 1'b0;
      fill_hold = 1'b0;
    end else begin
      checkOutput("almost_full", queue_almost_full, q_addr.size() >= AF);
      if (q_addr.size() == 0) begin
        checkOutput("idle_rd_valid", mem_read_valid, 0);
        checkOutput("idle_fill_valid", fill_valid, 0);
      end
      if (rd_hold) begin
        checkOutput("rd_valid_hold", mem_read_valid, 1);
        checkOutput("rd_addr_hold", mem_read_addr, rd_hold_addr);
      end
      if (fill_hold) begin
        checkOutput("fill_valid_hold", fill_valid, 1);
        checkOutput("fill_addr_hold", fill_addr, fill_hold_addr);
        checkOutput("fill_data_hold", fill_data, fill_hold_data);
        checkOutput("fill_dup_hold", fill_is_duplicate, fill_hold_dup);
      end
      rd_hold        = mem_read_valid && !mem_read_ready;
      rd_hold_addr   = mem_read_addr;
      fill_hold      = fill_valid && !fill_ready;
      fill_hold_addr = fill_addr;
      fill_hold_data = fill_data;
      fill_hold_dup  = fill_is_duplicate;
      if (mem_read_valid && mem_read_ready) rd_handshakes++;
      if (fill_valid && fill_ready) begin
        if (q_addr.size() == 0) begin
          checkOutput("fill_unexpected", 1, 0);
        end else begin
          ea = q_addr.pop_front();
          ed = q_dup.pop_front();
          el = '0;
          if (!ed) begin
            if (exp_lines.size() > 0) el = exp_lines.pop_front();
            else checkOutput("fill_before_data", 1, 0);
          end
          checkOutput("fill_addr", fill_addr, ea);
          checkOutput("fill_dup", fill_is_duplicate, ed);
          checkOutput("fill_data", fill_data, el);
          fills_done++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LB-1:0] line;
    logic [AW-1:0] a;
    bit            d, ok;
    int            r0, f0, n;

    reset = 1'b1;
    enqueue_valid = 0; enqueue_addr = '0; enqueue_duplicate = 0;
    mem_read_ready = 0; mem_data_valid = 0; mem_data = '0; fill_ready = 0;
    repeat (3) step();
    checkOutput("rst_almost_full", queue_almost_full, 0);
    checkOutput("rst_rd_valid", mem_read_valid, 0);
    checkOutput("rst_fill_valid", fill_valid, 0);
    checkOutput("rst_fill_data", fill_data, 0);
    reset = 1'b0;
    step();

    // Single miss with beats 0x0..0xF and exact latency checks.
    $display("[TB] single miss");
    applyStimulus(26'h1234, 1'b0);
    checkOutput("lat_rd_early", mem_read_valid, 0);
    step();
    checkOutput("lat_rd_valid", mem_read_valid, 1);
    checkOutput("lat_rd_addr", mem_read_addr, 26'h1234);
    do_read(0);
    line = '0;
    send_beats(0, BEATS - 1, 0, 1'b1, line);
    exp_lines.push_back(line);
    checkOutput("lat_fill_valid", fill_valid, 1);
    checkOutput("single_addr", fill_addr, 26'h1234);
    checkOutput("single_top_word", fill_data[LB-1 -: 32], 32'h0);
    checkOutput("single_low_word", fill_data[31:0], 32'hF);
    checkOutput("single_dup", fill_is_duplicate, 0);
    do_fill(0);
    checkOutput("fill_one_cycle", fill_valid, 0);

    // Duplicate queued behind its original miss.
    $display("[TB] duplicate after miss");
    r0 = rd_handshakes; f0 = fills_done;
    applyStimulus(26'h40, 1'b0);
    applyStimulus(26'h40, 1'b1);
    service(0, 0, 0);
    service(0, 0, 0);
    checkOutput("dup_read_count", rd_handshakes - r0, 1);
    checkOutput("dup_fill_count", fills_done - f0, 2);

    // Backpressure on both handshakes.
    $display("[TB] backpressure");
    r0 = rd_handshakes; f0 = fills_done;
    applyStimulus(26'h77, 1'b0);
    service(5, 7, 1);
    checkOutput("bp_read_count", rd_handshakes - r0, 1);
    checkOutput("bp_fill_count", fills_done - f0, 1);

    // Queue depth, a push during a pop, and a drain that wraps the pointers.
    $display("[TB] queue depth");
    for (int i = 0; i < AF; i++) begin
      applyStimulus(26'h100 + 26'(i), 1'b0);
      if (i == AF - 2) checkOutput("af_at_11", queue_almost_full, 0);
    end
    checkOutput("af_at_12", queue_almost_full, 1);
    do_read(0);
    line = '0;
    send_beats(0, BEATS - 1, 0, 1'b0, line);
    exp_lines.push_back(line);
    wait_fill(ok);
    fill_ready = 1'b1;
    applyStimulus(26'h200, 1'b0);
    fill_ready = 1'b0;
    checkOutput("push_pop_af", queue_almost_full, 1);
    n = 0;
    while (q_addr.size() > 0 && n < 20) begin service(0, 0, 0); n++; end

    // Reset in the middle of the beat stream.
    $display("[TB] reset mid-data");
    applyStimulus(26'h3C0, 1'b0);
    do_read(0);
    line = '0;
    send_beats(0, 7, 0, 1'b0, line);
    reset = 1'b1;
    #1;
    q_addr.delete(); q_dup.delete(); exp_lines.delete();
    checkOutput("mid_rst_rd_valid", mem_read_valid, 0);
    checkOutput("mid_rst_rd_addr", mem_read_addr, 0);
    checkOutput("mid_rst_fill_valid", fill_valid, 0);
    checkOutput("mid_rst_fill_data", fill_data, 0);
    checkOutput("mid_rst_af", queue_almost_full, 0);
    step();
    reset = 1'b0;
    line = '0;
    send_beats(8, BEATS - 1, 0, 1'b0, line);
    step();
    checkOutput("stray_fill_valid", fill_valid, 0);
    checkOutput("stray_rd_valid", mem_read_valid, 0);
    f0 = fills_done;
    applyStimulus(26'h3C4, 1'b0);
    service(1, 1, 1);
    checkOutput("post_rst_fill_count", fills_done - f0, 1);

    // Randomized rounds.
    $display("[TB] random rounds");
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        d = (q_addr.size() > 0) && ($urandom_range(0, 2) == 0);
        a = d ? q_addr[q_addr.size() - 1] : AW'($urandom);
        applyStimulus(a, d);
      end
      n = 0;
      while (q_addr.size() > 0 && n < 10) begin
        service($urandom_range(0, 3), $urandom_range(0, 3), 2);
        n++;
      end
      if (q_addr.size() != 0) begin
        checkOutput("round_drain", q_addr.size(), 0);
        q_addr.delete(); q_dup.delete(); exp_lines.delete();
      end
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
